// File: rtl/uart_tx_arbiter_if.sv
// AXI-Stream bundle between the byte requesters, the arbiter and the UART transmitter.
// The arbiter uses the slave modport; whatever drives the requesters and the UART uses master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata_i;
  logic [NUM_REQ-1:0]            s_axis_tvalid_i;
  logic [NUM_REQ-1:0]            s_axis_tlast_i;
  logic [NUM_REQ-1:0]            s_axis_tready_o;
  logic [DATA_WIDTH-1:0]         m_axis_tdata_o;
  logic                          m_axis_tvalid_o;
  logic                          m_axis_tlast_o;
  logic                          m_axis_tready_i;

  modport slave (
    input  s_axis_tdata_i, s_axis_tvalid_i, s_axis_tlast_i, m_axis_tready_i,
    output s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o
  );

  modport master (
    output s_axis_tdata_i, s_axis_tvalid_i, s_axis_tlast_i, m_axis_tready_i,
    input  s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX stream among NUM_REQ byte sources,
// with a watchdog that reclaims the grant from a requester stalling mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int          PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
  logic [15:0]      wdog_q, wdog_d;

  logic [PTR_W-1:0]      winner;
  logic                  any_req;
  int                    idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  handshake;
  logic                  expire;

  // First valid requester found searching upward from the one after the last served.
  always_comb begin
    winner  = last_ptr_q;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_ptr_q) + i) % NUM_REQ;
      if (!any_req && bus.s_axis_tvalid_i[idx]) begin
        any_req = 1'b1;
        winner  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    sel_data  = bus.s_axis_tdata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_valid = bus.s_axis_tvalid_i[grant_q];
    sel_last  = bus.s_axis_tlast_i[grant_q];
  end

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    last_ptr_d           = last_ptr_q;
    wdog_d               = wdog_q;
    bus.s_axis_tready_o  = '0;
    bus.m_axis_tdata_o   = '0;
    bus.m_axis_tvalid_o  = 1'b0;
    bus.m_axis_tlast_o   = 1'b0;
    grant_o              = '0;
    busy_o               = 1'b0;
    timeout_o            = 1'b0;
    handshake            = 1'b0;
    expire               = 1'b0;

    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (any_req) begin
          state_d = LOCKED;
          grant_d = winner;
        end
      end

      LOCKED: begin
        bus.m_axis_tdata_o           = sel_data;
        bus.m_axis_tvalid_o          = sel_valid;
        bus.m_axis_tlast_o           = sel_last;
        bus.s_axis_tready_o[grant_q] = bus.m_axis_tready_i;
        grant_o[grant_q]             = 1'b1;
        busy_o                       = 1'b1;

        handshake = sel_valid && bus.m_axis_tready_i;
        expire    = WDOG_EN && !sel_valid && (wdog_q == WDOG_LAST);

        // Only a silent requester ages the watchdog; UART backpressure merely holds it.
        if (handshake) begin
          wdog_d = '0;
        end else if (!sel_valid) begin
          wdog_d = wdog_q + 16'd1;
        end

        if ((handshake && sel_last) || expire) begin
          state_d    = IDLE;
          last_ptr_d = grant_q;
        end
        timeout_o = expire;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= PTR_W'(NUM_REQ - 1);
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      wdog_q     <= wdog_d;
    end
  end

endmodule
